// File: rtl/ev22_pkg.sv
// Shared types and instruction-field constants for the EV22 sequencer.
// The FAULT state only exists when EV22_WDOG_EN is defined.
package ev22_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_EXEC_WAIT
`ifdef EV22_WDOG_EN
    , S_FAULT
`endif
  } state_e;

  localparam logic [1:0] CLASS_JUMP = 2'b11;

  localparam logic [1:0] COND_JCY = 2'b11;
  localparam logic [1:0] COND_JNE = 2'b10;
  localparam logic [1:0] COND_JZE = 2'b01;
  localparam logic [1:0] COND_JMP = 2'b00;

  localparam int CLASS_HI = 15;
  localparam int CLASS_LO = 14;
  localparam int COND_HI  = 13;
  localparam int COND_LO  = 12;
  localparam int TGT_HI   = 10;
  localparam int TGT_LO   = 0;

  function automatic logic is_jump(input logic [15:0] ir);
    return ir[CLASS_HI:CLASS_LO] == CLASS_JUMP;
  endfunction

  function automatic logic [1:0] instr_cond(input logic [15:0] ir);
    return ir[COND_HI:COND_LO];
  endfunction

endpackage

// File: rtl/ev22_sequencer_if.sv
// Program-memory fetch bus and datapath exec handshake of the EV22 sequencer.
// master = sequencer side, slave = memory/datapath side.
interface ev22_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic              MEM_RD;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RDY;
  logic [15:0]       MEM_DATA;
  logic              CY;
  logic [15:0]       W;
  logic [15:0]       IR;
  logic              EXEC_STB;
  logic              EXEC_DONE;

  modport master (
    output MEM_RD, MEM_ADDR, IR, EXEC_STB,
    input  MEM_RDY, MEM_DATA, CY, W, EXEC_DONE
  );

  modport slave (
    input  MEM_RD, MEM_ADDR, IR, EXEC_STB,
    output MEM_RDY, MEM_DATA, CY, W, EXEC_DONE
  );
endinterface

// File: rtl/ev22_jump_cond.sv
// Jump-condition evaluator: decides whether a jump-class instruction is taken
// from its condition code and the live datapath flags.
module ev22_jump_cond
  import ev22_pkg::*;
(
  input  logic [1:0]  cond,
  input  logic        CY,
  input  logic [15:0] W,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_JCY: taken = CY;
      COND_JNE: taken = W[15];
      COND_JZE: taken = (W == 16'h0000);
      COND_JMP: taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ev22_sequencer.sv
// EV22 instruction sequencer: fetch, resolve jumps locally, hand other classes to the datapath.
// Define EV22_WDOG_EN to add a watchdog on FETCH/EXEC_WAIT that traps into a sticky FAULT state.
module ev22_sequencer
  import ev22_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int RESET_VEC   = 0,
  parameter int WDOG_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HALT,
  ev22_sequencer_if.master  bus,
  output logic              JUMP_TAKEN,
  output logic [ADDR_W-1:0] PC,
  output logic              FAULT
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              jt_q, jt_d;
  logic              taken;

  ev22_jump_cond u_jump_cond (
    .cond  (instr_cond(ir_q)),
    .CY    (bus.CY),
    .W     (bus.W),
    .taken (taken)
  );

`ifdef EV22_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 255) ? $clog2(WDOG_CYCLES + 1) : 8;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
  logic wdog_unused;
  assign wdog_unused = |WDOG_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    jt_d    = 1'b0;
    case (state_q)
      S_IDLE: if (!HALT) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.MEM_RDY) begin
          ir_d    = bus.MEM_DATA;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_jump(ir_q)) begin
          if (taken) begin
            pc_d = ir_q[ADDR_W-1:0];
            jt_d = 1'b1;
          end
          state_d = HALT ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_EXEC_WAIT;
      S_EXEC_WAIT: if (bus.EXEC_DONE) state_d = HALT ? S_IDLE : S_FETCH;
`ifdef EV22_WDOG_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef EV22_WDOG_EN
    // Counter runs only while stuck in a wait state; any exit restarts it at zero.
    wdog_d = '0;
    if ((state_q == S_FETCH || state_q == S_EXEC_WAIT) && state_d == state_q) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) state_d = S_FAULT;
      else                                     wdog_d  = wdog_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_VEC);
      ir_q    <= '0;
      jt_q    <= 1'b0;
`ifdef EV22_WDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      jt_q    <= jt_d;
`ifdef EV22_WDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign bus.MEM_RD   = (state_q == S_FETCH);
  assign bus.MEM_ADDR = pc_q;
  assign bus.EXEC_STB = (state_q == S_EXEC);
  assign bus.IR       = ir_q;
  assign PC           = pc_q;
  assign JUMP_TAKEN   = jt_q;
`ifdef EV22_WDOG_EN
  assign FAULT        = (state_q == S_FAULT);
`else
  assign FAULT        = 1'b0;
`endif

endmodule

// File: tb/tb_ev22_sequencer.sv
// Directed bench for ev22_sequencer: a table-driven program walk plus hand
// sequences for stalls, HALT at boundaries, and the stall/watchdog/reset path.
module tb_ev22_sequencer;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt;
  logic              jump_taken;
  logic [ADDR_W-1:0] pc;
  logic              fault;
  logic [15:0]       mem [0:2047];

  int n_cmp = 0;
  int n_bad = 0;

  ev22_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  ev22_sequencer #(.ADDR_W(ADDR_W), .RESET_VEC(0), .WDOG_CYCLES(255)) dut (
    .CLK        (clk),
    .RST        (rst),
    .HALT       (halt),
    .bus        (bus),
    .JUMP_TAKEN (jump_taken),
    .PC         (pc),
    .FAULT      (fault)
  );

  always #5 clk = ~clk;
  assign bus.MEM_DATA = mem[bus.MEM_ADDR];

  typedef struct {
    logic [10:0] addr;
    logic [15:0] instr;
    logic        cy;
    logic [15:0] w;
    logic        exp_jump;
    logic [10:0] exp_next;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Jump encodings carry class 2'b11 in [15:14]: D=JZE, E=JNE, F=JCY, C=JMP.
    vecs[0]  = '{11'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 11'h001};
    vecs[1]  = '{11'h001, 16'hC005, 1'b0, 16'h0000, 1'b1, 11'h005};
    vecs[2]  = '{11'h005, 16'hD123, 1'b0, 16'h0000, 1'b1, 11'h123};
    vecs[3]  = '{11'h123, 16'hC005, 1'b0, 16'h1234, 1'b1, 11'h005};
    vecs[4]  = '{11'h005, 16'hD123, 1'b1, 16'h0001, 1'b0, 11'h006};
    vecs[5]  = '{11'h006, 16'hF200, 1'b0, 16'hFFFF, 1'b0, 11'h007};
    vecs[6]  = '{11'h007, 16'hF200, 1'b1, 16'h0000, 1'b1, 11'h200};
    vecs[7]  = '{11'h200, 16'hE040, 1'b0, 16'h8000, 1'b1, 11'h040};
    vecs[8]  = '{11'h040, 16'hE100, 1'b1, 16'h7FFF, 1'b0, 11'h041};
    vecs[9]  = '{11'h041, 16'h4ABC, 1'b1, 16'h0000, 1'b0, 11'h042};
    vecs[10] = '{11'h042, 16'h8000, 1'b0, 16'h0000, 1'b0, 11'h043};
    vecs[11] = '{11'h043, 16'hC7FF, 1'b0, 16'h5555, 1'b1, 11'h7FF};
    vecs[12] = '{11'h7FF, 16'h0123, 1'b0, 16'h0000, 1'b0, 11'h000};

    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    foreach (vecs[i]) mem[vecs[i].addr] = vecs[i].instr;

    rst = 1'b1; halt = 1'b0;
    bus.MEM_RDY = 1'b1; bus.CY = 1'b0; bus.W = 16'h0000; bus.EXEC_DONE = 1'b0;
    tick(); tick();
    chk("rst_mem_rd", bus.MEM_RD, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mem_addr", bus.MEM_ADDR, 0);
    chk("rst_ir", bus.IR, 0);
    chk("rst_exec_stb", bus.EXEC_STB, 0);
    chk("rst_jump_taken", jump_taken, 0);
    chk("rst_fault", fault, 0);

    rst = 1'b0;
    chk("idle_cycle0_rd", bus.MEM_RD, 0);
    tick();

    // Program walk: each record is one instruction with immediate MEM_RDY
    // and EXEC_DONE one cycle after the strobe.
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      chk("fetch_rd", bus.MEM_RD, 1);
      chk("fetch_addr", bus.MEM_ADDR, v.addr);
      bus.CY = v.cy;
      bus.W  = v.w;
      tick();
      chk("decode_rd", bus.MEM_RD, 0);
      chk("decode_ir", bus.IR, v.instr);
      tick();
      if (v.instr[15:14] == 2'b11) begin
        chk("jump_taken", jump_taken, v.exp_jump);
        chk("jump_no_stb", bus.EXEC_STB, 0);
      end else begin
        chk("exec_stb", bus.EXEC_STB, 1);
        chk("exec_no_jump", jump_taken, 0);
        tick();
        chk("stb_one_cycle", bus.EXEC_STB, 0);
        bus.EXEC_DONE = 1'b1;
        tick();
        bus.EXEC_DONE = 1'b0;
      end
      chk("next_pc", pc, v.exp_next);
    end

    // Delayed MEM_RDY: read held 4 cycles on a stable address.
    bus.MEM_RDY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_rd", bus.MEM_RD, 1);
      chk("stall_addr", bus.MEM_ADDR, 0);
      if (k == 3) bus.MEM_RDY = 1'b1;
      tick();
    end
    chk("stall_decode_rd", bus.MEM_RD, 0);
    bus.EXEC_DONE = 1'b1;
    tick();
    chk("stall_exec_stb", bus.EXEC_STB, 1);
    tick();
    chk("done_ignored_in_exec", bus.MEM_RD, 0);
    bus.EXEC_DONE = 1'b0;
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_wait_rd", bus.MEM_RD, 0);
      chk("halt_wait_stb", bus.EXEC_STB, 0);
    end
    bus.EXEC_DONE = 1'b1;
    tick();
    bus.EXEC_DONE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("halt_idle_rd", bus.MEM_RD, 0);
      tick();
    end
    chk("halt_idle_pc", pc, 1);
    halt = 1'b0;
    tick();
    chk("resume_rd", bus.MEM_RD, 1);
    chk("resume_addr", bus.MEM_ADDR, 1);

    // HALT at a jump boundary: fetch completes, jump resolves, then idle.
    halt = 1'b1;
    tick();
    chk("halt_fetch_ir", bus.IR, 16'hC005);
    tick();
    chk("halt_jump_pulse", jump_taken, 1);
    chk("halt_jump_rd", bus.MEM_RD, 0);
    chk("halt_jump_pc", pc, 5);
    tick();
    chk("halt_jump_idle_rd", bus.MEM_RD, 0);
    chk("jump_pulse_ends", jump_taken, 0);
    halt = 1'b0;
    tick();
    chk("halt_jump_resume", bus.MEM_ADDR, 5);

    // Starved fetch: traps into FAULT when the watchdog exists, else waits forever.
    bus.MEM_RDY = 1'b0;
`ifdef EV22_WDOG_EN
    begin
      int n;
      n = 0;
      while (bus.MEM_RD && n < 400) begin
        n++;
        tick();
      end
      chk("wdog_fetch_cycles", n, 255);
      chk("wdog_fault", fault, 1);
      chk("wdog_rd_low", bus.MEM_RD, 0);
      bus.MEM_RDY = 1'b1;
      tick(); tick();
      chk("wdog_fault_sticky", fault, 1);
      chk("wdog_fault_rd", bus.MEM_RD, 0);
    end
`else
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 300; k++) begin
        if (!bus.MEM_RD || fault || bus.MEM_ADDR != 11'h005) bad++;
        tick();
      end
      chk("stall_unbounded", bad, 0);
      chk("fault_tied_low", fault, 0);
    end
`endif

    rst = 1'b1;
    tick();
    chk("rerst_fault", fault, 0);
    chk("rerst_pc", pc, 0);
    chk("rerst_rd", bus.MEM_RD, 0);
    chk("rerst_ir", bus.IR, 0);
    bus.MEM_RDY = 1'b1;
    rst = 1'b0;
    tick();
    chk("rerst_fetch_rd", bus.MEM_RD, 1);
    chk("rerst_fetch_addr", bus.MEM_ADDR, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
